// File: rtl/ball_animator.sv
// rtl/ball_animator.sv - per-frame motion engine for three metaballs with edge reflection
//
// Advances three ball centres once per frame and publishes them together.
// A frame tick is the falling edge of vsync, sampled against its registered
// copy. Each tick runs one working-register update per ball over three
// cycles, then a commit cycle copies the whole set to the outputs.
//
// Ports:
//   clk            pixel clock
//   rst_n          asynchronous active-low reset
//   vsync          active-low vertical sync, synchronous to clk
//   pause          1 = discard frame ticks
//   ballN_x/_y     published ball centres (10 bits each)
//   busy           high from tick acceptance until commit
//   frame_done     one-cycle pulse when new positions are published
//   frame_cnt      count of committed updates, wraps at 256
module ball_animator #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int MARGIN        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       pause,
    output logic [9:0] ball0_x,
    output logic [9:0] ball0_y,
    output logic [9:0] ball1_x,
    output logic [9:0] ball1_y,
    output logic [9:0] ball2_x,
    output logic [9:0] ball2_y,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] frame_cnt
);

    localparam logic signed [10:0] MARGIN_S  = 11'(MARGIN);
    localparam logic signed [10:0] X_LIMIT_S = 11'(SCREEN_WIDTH - 1 - MARGIN);
    localparam logic signed [10:0] Y_LIMIT_S = 11'(SCREEN_HEIGHT - 1 - MARGIN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPD    = 2'd1,
        COMMIT = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic       vsync_q;
    logic       tick;

    // Working set: updated one ball per cycle while in UPD.
    logic [9:0] px_q [3];
    logic [9:0] py_q [3];
    logic [3:0] vx_q [3];
    logic [3:0] vy_q [3];

    // Published set: only ever written all at once in COMMIT.
    logic [9:0] pub_x_q [3];
    logic [9:0] pub_y_q [3];
    logic       frame_done_q;
    logic [7:0] frame_cnt_q;

    logic [13:0] x_res, y_res;

    // Returns {new_position, new_velocity}. Sum is formed in 11-bit signed so
    // a step below zero or past 1023 is still compared correctly.
    function automatic logic [13:0] step_axis(input logic [9:0] p,
                                              input logic [3:0] v,
                                              input logic signed [10:0] lim);
        logic signed [10:0] n;
        n = $signed({1'b0, p}) + $signed({{7{v[3]}}, v});
        if (n < MARGIN_S) begin
            step_axis = {MARGIN_S[9:0], -v};
        end else if (n > lim) begin
            step_axis = {lim[9:0], -v};
        end else begin
            step_axis = {n[9:0], v};
        end
    endfunction

    assign tick = vsync_q & ~vsync;

    always_comb begin
        x_res = step_axis(px_q[idx_q], vx_q[idx_q], X_LIMIT_S);
        y_res = step_axis(py_q[idx_q], vy_q[idx_q], Y_LIMIT_S);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (tick && !pause) begin
                    state_d = UPD;
                    idx_d   = 2'd0;
                end
            end
            UPD: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd2) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            vsync_q <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vsync_q <= vsync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_q[0] <= 10'd160;  py_q[0] <= 10'd120;
            px_q[1] <= 10'd320;  py_q[1] <= 10'd240;
            px_q[2] <= 10'd480;  py_q[2] <= 10'd360;
            vx_q[0] <= 4'sd2;    vy_q[0] <= 4'sd1;
            vx_q[1] <= -4'sd3;   vy_q[1] <= 4'sd2;
            vx_q[2] <= 4'sd1;    vy_q[2] <= -4'sd3;
        end else if (state_q == UPD) begin
            px_q[idx_q] <= x_res[13:4];
            vx_q[idx_q] <= x_res[3:0];
            py_q[idx_q] <= y_res[13:4];
            vy_q[idx_q] <= y_res[3:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pub_x_q[0]   <= 10'd160;  pub_y_q[0] <= 10'd120;
            pub_x_q[1]   <= 10'd320;  pub_y_q[1] <= 10'd240;
            pub_x_q[2]   <= 10'd480;  pub_y_q[2] <= 10'd360;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 8'd0;
        end else begin
            frame_done_q <= (state_q == COMMIT);
            if (state_q == COMMIT) begin
                for (int i = 0; i < 3; i++) begin
                    pub_x_q[i] <= px_q[i];
                    pub_y_q[i] <= py_q[i];
                end
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign ball0_x    = pub_x_q[0];
    assign ball0_y    = pub_y_q[0];
    assign ball1_x    = pub_x_q[1];
    assign ball1_y    = pub_y_q[1];
    assign ball2_x    = pub_x_q[2];
    assign ball2_y    = pub_y_q[2];

endmodule

// File: tb/tb_ball_animator.sv
// tb/tb_ball_animator.sv - self-checking bench for ball_animator
module tb_ball_animator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vsync;
    logic       pause;
    logic [9:0] ball0_x, ball0_y, ball1_x, ball1_y, ball2_x, ball2_y;
    logic       busy;
    logic       frame_done;
    logic [7:0] frame_cnt;

    ball_animator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync      (vsync),
        .pause      (pause),
        .ball0_x    (ball0_x),
        .ball0_y    (ball0_y),
        .ball1_x    (ball1_x),
        .ball1_y    (ball1_y),
        .ball2_x    (ball2_x),
        .ball2_y    (ball2_y),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef logic [67:0] snap_t;
    snap_t exp_q[$];

    localparam snap_t RESET_SNAP = {10'd160, 10'd120, 10'd320, 10'd240, 10'd480, 10'd360, 8'd0};
    localparam snap_t STEP1_SNAP = {10'd162, 10'd121, 10'd317, 10'd242, 10'd481, 10'd357, 8'd1};

    // Reference model of the working set.
    int mx[3], my[3], mvx[3], mvy[3];
    int mcnt;

    task automatic model_reset();
        mx  = '{160, 320, 480};
        my  = '{120, 240, 360};
        mvx = '{2, -3, 1};
        mvy = '{1, 2, -3};
        mcnt = 0;
    endtask

    task automatic model_step();
        int n;
        for (int i = 0; i < 3; i++) begin
            n = mx[i] + mvx[i];
            if (n < 16)       begin mx[i] = 16;  mvx[i] = -mvx[i]; end
            else if (n > 623) begin mx[i] = 623; mvx[i] = -mvx[i]; end
            else              mx[i] = n;
            n = my[i] + mvy[i];
            if (n < 16)       begin my[i] = 16;  mvy[i] = -mvy[i]; end
            else if (n > 463) begin my[i] = 463; mvy[i] = -mvy[i]; end
            else              my[i] = n;
        end
        mcnt = (mcnt + 1) % 256;
    endtask

    function automatic snap_t model_snap();
        return {10'(mx[0]), 10'(my[0]), 10'(mx[1]), 10'(my[1]),
                10'(mx[2]), 10'(my[2]), 8'(mcnt)};
    endfunction

    function automatic snap_t dut_snap();
        return {ball0_x, ball0_y, ball1_x, ball1_y, ball2_x, ball2_y, frame_cnt};
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Scoreboard: every published frame must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && frame_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_frame_done: got snapshot %h expected no frame", dut_snap());
            end else begin
                check("frame_publish", 72'(dut_snap()), 72'(exp_q.pop_front()));
            end
        end
    end

    task automatic wait_drain();
        for (int c = 0; c < 12 && exp_q.size() != 0; c++) @(negedge clk);
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL frame_timeout: got %0d pending frames expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic tick_step();
        @(negedge clk) vsync = 1'b0;
        @(negedge clk) vsync = 1'b1;
        model_step();
        exp_q.push_back(model_snap());
        wait_drain();
    endtask

    // Checkpoints after n ticks: sel 0..5 = b0x,b0y,b1x,b1y,b2x,b2y, 6 = frame_cnt.
    typedef struct {
        int n;
        int sel;
        int val;
    } cp_t;

    function automatic int sel_val(input int sel);
        case (sel)
            0: return int'(ball0_x);
            1: return int'(ball0_y);
            2: return int'(ball1_x);
            3: return int'(ball1_y);
            4: return int'(ball2_x);
            5: return int'(ball2_y);
            default: return int'(frame_cnt);
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cp_t cps[$];
        int  ci;
        logic seen;

        cps = '{
            '{2,   0, 164}, '{2,   3, 244},
            '{101, 2, 17},  '{102, 2, 16},  '{103, 2, 19},
            '{114, 5, 18},  '{115, 5, 16},  '{116, 5, 19},
            '{231, 0, 622}, '{232, 0, 623}, '{233, 0, 621},
            '{255, 6, 255}, '{256, 6, 0},
            '{343, 1, 463}, '{344, 1, 463}, '{345, 1, 462}
        };

        rst_n = 1'b0;
        vsync = 1'b1;
        pause = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_state", {2'b00, busy, frame_done, dut_snap()}, {2'b00, 1'b0, 1'b0, RESET_SNAP});

        // First tick, cycle by cycle.
        @(negedge clk) vsync = 1'b0;
        model_step();
        exp_q.push_back(model_snap());
        @(negedge clk) vsync = 1'b1;
        check("tick_k0", {2'b00, busy, frame_done, dut_snap()}, {2'b00, 1'b1, 1'b0, RESET_SNAP});
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check($sformatf("tick_k%0d", i), {2'b00, busy, frame_done, dut_snap()},
                  {2'b00, 1'b1, 1'b0, RESET_SNAP});
        end
        @(negedge clk);
        check("tick_k4", {2'b00, busy, frame_done, dut_snap()}, {2'b00, 1'b0, 1'b1, STEP1_SNAP});
        @(negedge clk);
        check("tick_k5", {2'b00, busy, frame_done, dut_snap()}, {2'b00, 1'b0, 1'b0, STEP1_SNAP});

        // Long run with table checkpoints.
        ci = 0;
        for (int n = 2; n <= 345; n++) begin
            tick_step();
            while (ci < cps.size() && cps[ci].n == n) begin
                check($sformatf("cp_n%0d_sel%0d", n, cps[ci].sel),
                      72'(sel_val(cps[ci].sel)), 72'(cps[ci].val));
                ci++;
            end
        end

        // Paused ticks are discarded.
        pause = 1'b1;
        seen  = 1'b0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk) vsync = 1'b0;
            @(negedge clk) vsync = 1'b1;
            repeat (6) begin
                @(negedge clk);
                seen = seen | busy | frame_done;
            end
        end
        check("pause_no_activity", 72'(seen), 72'(0));
        check("pause_hold", 72'(dut_snap()), 72'(model_snap()));
        pause = 1'b0;
        tick_step();

        // Second tick while busy is ignored.
        @(negedge clk) vsync = 1'b0;
        model_step();
        exp_q.push_back(model_snap());
        @(negedge clk) vsync = 1'b1;
        @(negedge clk) vsync = 1'b0;
        @(negedge clk) vsync = 1'b1;
        wait_drain();
        repeat (8) @(negedge clk);
        check("busy_tick_ignored", 72'(frame_cnt), 72'(mcnt));

        // Reset during UPD idx=1 aborts with no commit.
        @(negedge clk) vsync = 1'b0;
        @(negedge clk) vsync = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("reset_mid_update", {2'b00, busy, frame_done, dut_snap()}, {2'b00, 1'b0, 1'b0, RESET_SNAP});
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | frame_done | busy;
        end
        check("reset_no_commit", 72'(seen), 72'(0));
        check("reset_hold", 72'(dut_snap()), 72'(RESET_SNAP));
        model_reset();
        tick_step();
        check("post_reset_step", 72'(dut_snap()), 72'(STEP1_SNAP));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
